// File: rtl/alpha_cs_pkg.sv
// Shared types and constants for the chip-select sequencer.
//   cs_state_t  : sequencer FSM states
//   DEC_EN_*    : decoder enable patterns, ordered {e1, ne2, ne3}
//   OWNER_*     : bus owner encoding (owner output / round-robin history)
package alpha_cs_pkg;

    localparam int unsigned SEL_BITS = 3;
    localparam int unsigned NUM_SEL  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } cs_state_t;

    localparam logic [2:0] DEC_EN_ON  = 3'b100;
    localparam logic [2:0] DEC_EN_OFF = 3'b011;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/alpha_rr_arb2.sv
// Two-way round-robin arbiter between CPU and DMA requests.
//   cpu_req, dma_req : level requests
//   owner            : last granted requester (0 = CPU, 1 = DMA)
//   gnt_valid_c      : some request is pending
//   gnt_owner_c      : requester to grant (valid only with gnt_valid_c)
module alpha_rr_arb2
    import alpha_cs_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic owner,
    output logic gnt_valid_c,
    output logic gnt_owner_c
);

    // On a tie, grant whoever was not granted last.
    always_comb begin
        gnt_valid_c = cpu_req | dma_req;
        gnt_owner_c = OWNER_CPU;
        if (cpu_req && dma_req) begin
            gnt_owner_c = ~owner;
        end else if (dma_req) begin
            gnt_owner_c = OWNER_DMA;
        end
    end

endmodule

// File: rtl/alpha_cs_sequencer.sv
// Shares the board 3-to-8 chip-select decoder between the CPU and DMA.
// Each access: arbitrate, one setup cycle with the decoder disabled, W+1
// enabled cycles (W from the per-select wait table), ack on the last
// enabled cycle, then one recovery cycle.
//   clk, reset        : clock, synchronous active-high reset
//   cpu_req/sel/ack   : CPU request, target select, completion pulse
//   dma_req/sel/ack   : DMA request, target select, completion pulse
//   wait_tbl          : wait count per select, field k at k*WAIT_BITS
//   dec_in            : decoder select inputs
//   dec_e1/ne2/ne3    : decoder enables (active only in ACTIVE)
//   owner             : current/last grant, 0 = CPU, 1 = DMA
//   busy              : sequencer not idle
module alpha_cs_sequencer
    import alpha_cs_pkg::*;
#(
    parameter int unsigned WAIT_BITS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic [SEL_BITS-1:0]           cpu_sel,
    output logic                          cpu_ack,
    input  logic                          dma_req,
    input  logic [SEL_BITS-1:0]           dma_sel,
    output logic                          dma_ack,
    input  logic [NUM_SEL*WAIT_BITS-1:0]  wait_tbl,
    output logic [SEL_BITS-1:0]           dec_in,
    output logic                          dec_e1,
    output logic                          dec_ne2,
    output logic                          dec_ne3,
    output logic                          owner,
    output logic                          busy
);

    cs_state_t             state_q, state_d;
    logic [SEL_BITS-1:0]   sel_q, sel_d;
    logic [WAIT_BITS-1:0]  cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic [2:0]            en_q, en_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  dma_ack_q, dma_ack_d;
    logic                  busy_q, busy_d;

    logic                  gnt_valid_c;
    logic                  gnt_owner_c;
    logic                  done_c;
    logic [WAIT_BITS-1:0]  wait_fld [NUM_SEL];

    alpha_rr_arb2 u_arb (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .owner       (owner_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_owner_c (gnt_owner_c)
    );

    // Split the flat wait table into per-select fields.
    always_comb begin
        for (int k = 0; k < NUM_SEL; k++) begin
            wait_fld[k] = wait_tbl[k*WAIT_BITS +: WAIT_BITS];
        end
    end

    // Next state, latches and counter; outputs are derived from the next
    // state so that they register in step with it.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid_c) begin
                    state_d = SETUP;
                    owner_d = gnt_owner_c;
                    sel_d   = (gnt_owner_c == OWNER_DMA) ? dma_sel : cpu_sel;
                    cnt_d   = wait_fld[sel_d];
                end
            end
            SETUP: begin
                state_d = ACTIVE;
            end
            ACTIVE: begin
                // cnt only decrements while nonzero, so it never wraps.
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                end else begin
                    cnt_d = WAIT_BITS'(cnt_q - 1'b1);
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_c    = (state_d == ACTIVE) && (cnt_d == '0);
        en_d      = (state_d == ACTIVE) ? DEC_EN_ON : DEC_EN_OFF;
        cpu_ack_d = done_c && (owner_d == OWNER_CPU);
        dma_ack_d = done_c && (owner_d == OWNER_DMA);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            owner_q   <= OWNER_DMA;
            en_q      <= DEC_EN_OFF;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            en_q      <= en_d;
            cpu_ack_q <= cpu_ack_d;
            dma_ack_q <= dma_ack_d;
            busy_q    <= busy_d;
        end
    end

    // dec_in tracks the latched select; it holds through RECOVER and IDLE.
    assign dec_in                     = sel_q;
    assign {dec_e1, dec_ne2, dec_ne3} = en_q;
    assign cpu_ack                    = cpu_ack_q;
    assign dma_ack                    = dma_ack_q;
    assign owner                      = owner_q;
    assign busy                       = busy_q;

endmodule

// File: tb/tb_alpha_cs_sequencer.sv
// Self-checking bench for alpha_cs_sequencer: directed timing checks plus a
// scoreboard of expected accesses (owner, select, wait count) compared on
// every ack against the observed enable run length and decoder select.
module tb_alpha_cs_sequencer;
    import alpha_cs_pkg::*;

    localparam int unsigned WB = 3;

    typedef struct {
        logic        own;
        logic [2:0]  sel;
        int unsigned w;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, dma_req;
    logic [2:0]        cpu_sel, dma_sel;
    logic              cpu_ack, dma_ack;
    logic [8*WB-1:0]   wait_tbl;
    logic [2:0]        dec_in;
    logic              dec_e1, dec_ne2, dec_ne3;
    logic              owner, busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];
    int unsigned run = 0;
    logic        exp_last;

    alpha_cs_sequencer #(.WAIT_BITS(WB)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_sel  (cpu_sel),
        .cpu_ack  (cpu_ack),
        .dma_req  (dma_req),
        .dma_sel  (dma_sel),
        .dma_ack  (dma_ack),
        .wait_tbl (wait_tbl),
        .dec_in   (dec_in),
        .dec_e1   (dec_e1),
        .dec_ne2  (dec_ne2),
        .dec_ne3  (dec_ne3),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned fld(input logic [2:0] k);
        logic [8*WB-1:0] t;
        t = wait_tbl;
        return int'(t[int'(k)*WB +: WB]);
    endfunction

    task automatic push(input logic own, input logic [2:0] sel);
        exp_t e;
        e.own = own;
        e.sel = sel;
        e.w   = fld(sel);
        sb.push_back(e);
        exp_last = own;
    endtask

    task automatic set_fld(input int k, input int unsigned v);
        wait_tbl[k*WB +: WB] = WB'(v);
    endtask

    // Wait (bounded) for the next ack; returns at the negedge of the ack cycle.
    task automatic wait_ack(output logic got_cpu, output logic got_dma);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cpu_ack || dma_ack) && n < 60);
        check("ack_timeout", 32'(cpu_ack || dma_ack), 32'd1);
        got_cpu = cpu_ack;
        got_dma = dma_ack;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_dec_in"}, 32'(dec_in), 32'd0);
        check({tag, "_en"}, 32'({dec_e1, dec_ne2, dec_ne3}), 32'(DEC_EN_OFF));
        check({tag, "_acks"}, 32'({cpu_ack, dma_ack}), 32'd0);
        check({tag, "_owner"}, 32'(owner), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: enable encoding, no enables while idle, no overlapping acks,
    // and scoreboard comparison on every ack.
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else begin
            logic [2:0] en;
            exp_t e;
            en = {dec_e1, dec_ne2, dec_ne3};
            check("en_code", 32'(en == DEC_EN_ON || en == DEC_EN_OFF), 32'd1);
            check("en_while_idle", 32'(en == DEC_EN_ON && !busy), 32'd0);
            check("ack_overlap", 32'(cpu_ack && dma_ack), 32'd0);
            if (en == DEC_EN_ON) run++;
            if (cpu_ack || dma_ack) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_ack_owner", 32'(dma_ack), 32'(e.own));
                    check("sb_owner_out", 32'(owner), 32'(e.own));
                    check("sb_dec_in", 32'(dec_in), 32'(e.sel));
                    check("sb_active_len", run, e.w + 1);
                end
            end
            if (en != DEC_EN_ON) run = 0;
        end
    end

    initial begin
        logic gc, gd;
        int unsigned acks;

        reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
        cpu_sel = '0; dma_sel = '0; wait_tbl = '0;
        exp_last = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("rst");
        @(negedge clk) reset = 1'b0;

        // CPU, select 5, zero wait: directed cycle timing.
        @(negedge clk);
        set_fld(5, 0);
        cpu_sel = 3'd5; cpu_req = 1'b1;
        push(OWNER_CPU, 3'd5);
        @(posedge clk); #1;
        check("t1_setup_busy", 32'(busy), 32'd1);
        check("t1_setup_en", 32'({dec_e1, dec_ne2, dec_ne3}), 32'(DEC_EN_OFF));
        check("t1_setup_owner", 32'(owner), 32'd0);
        @(posedge clk); #1;
        check("t1_active_en", 32'({dec_e1, dec_ne2, dec_ne3}), 32'(DEC_EN_ON));
        check("t1_active_dec", 32'(dec_in), 32'd5);
        check("t1_ack", 32'({cpu_ack, dma_ack}), 32'b10);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("t1_recover_en", 32'({dec_e1, dec_ne2, dec_ne3}), 32'(DEC_EN_OFF));
        check("t1_recover_ack", 32'({cpu_ack, dma_ack}), 32'd0);
        check("t1_recover_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_dec_hold", 32'(dec_in), 32'd5);

        // DMA, select 2, wait 3.
        @(negedge clk);
        set_fld(2, 3);
        dma_sel = 3'd2; dma_req = 1'b1;
        push(OWNER_DMA, 3'd2);
        wait_ack(gc, gd);
        check("t2_dma_ack", 32'({gc, gd}), 32'b01);
        dma_req = 1'b0;
        repeat (3) @(negedge clk);

        // Both held: CPU, DMA, CPU, DMA.
        set_fld(1, 2); set_fld(6, 1);
        cpu_sel = 3'd1; dma_sel = 3'd6;
        cpu_req = 1'b1; dma_req = 1'b1;
        push(OWNER_CPU, 3'd1); push(OWNER_DMA, 3'd6);
        push(OWNER_CPU, 3'd1); push(OWNER_DMA, 3'd6);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(gc, gd);
            acks++;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check("t3_ack_count", acks, 32'd4);
        repeat (3) @(negedge clk);

        // CPU req withdrawn after grant; wait table changed mid-ACTIVE.
        set_fld(3, 3);
        cpu_sel = 3'd3; cpu_req = 1'b1;
        push(OWNER_CPU, 3'd3);
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        set_fld(3, 7);
        wait_ack(gc, gd);
        check("t4_ack_after_drop", 32'({gc, gd}), 32'b10);
        repeat (3) @(negedge clk);

        // Maximum wait: 8 enabled cycles, no wrap.
        set_fld(4, 7);
        dma_sel = 3'd4; dma_req = 1'b1;
        push(OWNER_DMA, 3'd4);
        wait_ack(gc, gd);
        dma_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during ACTIVE: no ack, reset values, owner back to DMA.
        set_fld(0, 7);
        cpu_sel = 3'd0; set_fld(7, 7); cpu_sel = 3'd7; cpu_req = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_in_active", 32'(dec_e1), 32'd1);
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1 chk_reset_vals("t6");
        repeat (2) begin
            @(posedge clk); #1;
            check("t6_no_ack", 32'({cpu_ack, dma_ack}), 32'd0);
        end
        @(negedge clk) reset = 1'b0;
        exp_last = 1'b1;
        @(negedge clk);

        // Random request stream.
        for (int it = 0; it < 24; it++) begin
            int unsigned mode;
            logic [2:0] cs, ds;
            mode = $urandom_range(2, 0);
            for (int k = 0; k < 8; k++) set_fld(k, $urandom_range(7, 0));
            cs = 3'($urandom_range(7, 0));
            ds = 3'($urandom_range(7, 0));
            cpu_sel = cs; dma_sel = ds;
            cpu_req = (mode != 1); dma_req = (mode != 0);
            if (mode == 0) push(OWNER_CPU, cs);
            else if (mode == 1) push(OWNER_DMA, ds);
            else if (exp_last == OWNER_DMA) begin
                push(OWNER_CPU, cs); push(OWNER_DMA, ds);
            end else begin
                push(OWNER_DMA, ds); push(OWNER_CPU, cs);
            end
            for (int j = 0; j < ((mode == 2) ? 2 : 1); j++) begin
                wait_ack(gc, gd);
                if (gc) cpu_req = 1'b0;
                if (gd) dma_req = 1'b0;
            end
            cpu_req = 1'b0; dma_req = 1'b0;
            repeat (3) @(negedge clk);
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
